mux4_rr_arbiter: RTL

- Four-requester round-robin arbiter with a registered output stage. It sits directly upstream of the 4:1 mux datapath.
- Picks one of four valid/ready input channels per cycle and drives a 2-bit select (out_sel) that the downstream 4:1 mux consumes.
- Forwards the winning channel's payload through a one-entry output buffer with valid/ready handshake.
- Gives fair, starvation-free access to a shared downstream port.

---
 rtl/mux4_rr_arbiter_pkg.sv | 22 ++
 rtl/mux4_rr_arbiter_rr_pick4.sv | 27 ++
 rtl/mux4_rr_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants, buffer state encoding and helpers for the mux4_rr_arbiter slice.
package mux4_rr_arbiter_pkg;

  localparam int NUM_CH   = 4;
  localparam int SEL_W    = 2;
  localparam int DATA_RST = 0;

  localparam logic [SEL_W-1:0] PTR_RST = 2'd3;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  function automatic logic [NUM_CH-1:0] sel_to_oh(input logic [SEL_W-1:0] sel);
    logic [NUM_CH-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin pick: first valid channel in the order ptr+1, ptr+2, ptr+3, ptr.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [NUM_CH-1:0] valid,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  winner,
  output logic [NUM_CH-1:0] winner_oh,
  output logic              any_valid
);

  logic [SEL_W-1:0] idx;

  // Walk from lowest to highest priority so the highest-priority hit is assigned last.
  always_comb begin
    winner    = '0;
    winner_oh = '0;
    idx       = '0;
    any_valid = |valid;
    for (int off = NUM_CH; off >= 1; off--) begin
      idx = ptr + SEL_W'(off);
      if (valid[idx]) winner = idx;
    end
    if (any_valid) winner_oh = sel_to_oh(winner);
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Four-channel round-robin arbiter feeding a one-entry registered output buffer.
// Defining MUX4_RR_ARBITER_BURST_LOCK_EN adds in_last/out_last and locks the grant for bursts.
module mux4_rr_arbiter #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          in_valid,
  input  logic [4*DATA_W-1:0] in_data,
  output logic [3:0]          in_ready,
`ifdef MUX4_RR_ARBITER_BURST_LOCK_EN
  input  logic [3:0]          in_last,
  output logic                out_last,
`endif
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [1:0]          out_sel,
  input  logic                out_ready,
  output logic [3:0]          grant_oh
);
  import mux4_rr_arbiter_pkg::*;

  // state     | meaning
  // BUF_EMPTY | no word buffered, out_valid=0
  // BUF_FULL  | word held in out_data/out_sel, out_valid=1

  if (NUM_CH != mux4_rr_arbiter_pkg::NUM_CH) begin : g_bad_num_ch
    $error("mux4_rr_arbiter supports exactly four channels");
  end

  buf_state_e        state_q;
  buf_state_e        state_d;
  logic [SEL_W-1:0]  ptr;
  logic [3:0]        lock_mask;
  logic [3:0]        pick_valid;
  logic [3:0]        win_oh;
  logic [SEL_W-1:0]  win;
  logic              any_win;
  logic              load_en;
  logic              xfer;
  logic [DATA_W-1:0] win_data;

`ifdef MUX4_RR_ARBITER_BURST_LOCK_EN
  logic locked;

  // While locked, ptr still names the burst owner since it was the last accepted channel.
  assign lock_mask = locked ? sel_to_oh(ptr) : 4'hF;
`else
  assign lock_mask = 4'hF;
`endif

  assign pick_valid = in_valid & lock_mask;

  rr_pick4 u_pick (
    .valid     (pick_valid),
    .ptr       (ptr),
    .winner    (win),
    .winner_oh (win_oh),
    .any_valid (any_win)
  );

  assign win_data = in_data[int'(win)*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (rst) state_q <= BUF_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (xfer)           state_d = BUF_FULL;
    else if (out_ready) state_d = BUF_EMPTY;
  end

  always_comb begin
    out_valid = (state_q == BUF_FULL);
    load_en   = !out_valid || out_ready;
    xfer      = any_win && load_en;
    in_ready  = (rst || !load_en) ? 4'b0000 : win_oh;
    grant_oh  = out_valid ? sel_to_oh(out_sel) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= DATA_W'(DATA_RST);
      out_sel  <= '0;
      ptr      <= PTR_RST;
    end else if (xfer) begin
      out_data <= win_data;
      out_sel  <= win;
      ptr      <= win;
    end
  end

`ifdef MUX4_RR_ARBITER_BURST_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      locked   <= 1'b0;
      out_last <= 1'b0;
    end else if (xfer) begin
      locked   <= !in_last[win];
      out_last <= in_last[win];
    end
  end
`endif

endmodule
